// File: rtl/tff_pkg.sv
// Shared definitions for the toggle-flop bank: opcodes and the D/T-to-toggle-mask helper.
// The helper works on 64-bit operands so any bank width up to 64 can slice its result.
package tff_pkg;

  typedef logic [1:0] tff_op_t;

  localparam tff_op_t TFF_OP_LOAD    = 2'b00;
  localparam tff_op_t TFF_OP_TOGGLE  = 2'b01;
  localparam tff_op_t TFF_OP_RESTORE = 2'b10;
  localparam tff_op_t TFF_OP_NOP     = 2'b11;

  localparam int TFF_MAX_W = 64;

  function automatic logic [TFF_MAX_W-1:0] tff_mask(
    input tff_op_t              op,
    input logic [TFF_MAX_W-1:0] data,
    input logic [TFF_MAX_W-1:0] q,
    input logic [TFF_MAX_W-1:0] rst
  );
    logic [TFF_MAX_W-1:0] t;
    case (op)
      TFF_OP_LOAD:    t = data ^ q;
      TFF_OP_TOGGLE:  t = data;
      TFF_OP_RESTORE: t = q ^ rst;
      default:        t = '0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/tff_popcount.sv
// Combinational population count: number of set bits in a WIDTH-bit vector.
module tff_popcount #(
  parameter int WIDTH = 8,
  parameter int OUT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] bits,
  output logic [OUT_W-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count = count + OUT_W'(bits[i]);
    end
  end

endmodule

// File: rtl/tff_toggle_bank.sv
// Register bank of toggle flops: commands become per-bit toggle masks applied to Q,
// with each applied mask reported downstream and a saturating toggle-activity count.
module tff_toggle_bank
  import tff_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = 16
) (
  input  logic             C,
  input  logic             R,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] Q,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_mask,
  output logic [WIDTH-1:0] res_q,
  input  logic             act_clr,
  output logic [CNT_W-1:0] act_cnt
);

  localparam int PC_W = $clog2(WIDTH + 1);

  logic             a_valid_reg;
  tff_op_t          a_op_reg;
  logic [WIDTH-1:0] a_data_reg;
  logic [WIDTH-1:0] q_reg;
  logic             res_valid_reg;
  logic [WIDTH-1:0] res_mask_reg;
  logic [WIDTH-1:0] res_q_reg;
  logic [CNT_W-1:0] act_cnt_reg;

  logic                 advance;
  logic                 accept;
  logic [TFF_MAX_W-1:0] t_wide;
  logic [WIDTH-1:0]     t_mask;
  logic [PC_W-1:0]      t_pop;
  logic [CNT_W:0]       cnt_sum;
  logic [CNT_W-1:0]     cnt_next;

  assign advance = a_valid_reg && (!res_valid_reg || res_ready);
  assign in_ready = !a_valid_reg || advance;
  assign accept = in_valid && in_ready;

  // Compute and apply share a stage, so the mask always sees the latest Q.
  assign t_wide = tff_mask(a_op_reg, TFF_MAX_W'(a_data_reg), TFF_MAX_W'(q_reg),
                           TFF_MAX_W'(RESET_VAL));
  assign t_mask = t_wide[WIDTH-1:0];

  tff_popcount #(
    .WIDTH (WIDTH),
    .OUT_W (PC_W)
  ) u_popcount (
    .bits  (t_mask),
    .count (t_pop)
  );

  assign cnt_sum  = {1'b0, act_cnt_reg} + (CNT_W + 1)'(t_pop);
  assign cnt_next = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];

  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      a_valid_reg <= 1'b0;
      a_op_reg    <= TFF_OP_NOP;
      a_data_reg  <= '0;
    end else if (accept) begin
      a_valid_reg <= 1'b1;
      a_op_reg    <= tff_op_t'(in_op);
      a_data_reg  <= in_data;
    end else if (advance) begin
      a_valid_reg <= 1'b0;
    end
  end

  // Bank flops: explicit toggle update so they map onto T-flop cells.
  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      q_reg <= RESET_VAL;
    end else if (advance) begin
      q_reg <= q_reg ^ t_mask;
    end
  end

  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      res_valid_reg <= 1'b0;
      res_mask_reg  <= '0;
      res_q_reg     <= RESET_VAL;
    end else if (advance) begin
      res_valid_reg <= 1'b1;
      res_mask_reg  <= t_mask;
      res_q_reg     <= q_reg ^ t_mask;
    end else if (res_ready) begin
      res_valid_reg <= 1'b0;
    end
  end

  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      act_cnt_reg <= '0;
    end else if (act_clr) begin
      act_cnt_reg <= '0;
    end else if (advance) begin
      act_cnt_reg <= cnt_next;
    end
  end

  assign Q         = q_reg;
  assign res_valid = res_valid_reg;
  assign res_mask  = res_mask_reg;
  assign res_q     = res_q_reg;
  assign act_cnt   = act_cnt_reg;

endmodule

// File: tb/tb_tff_toggle_bank.sv
// Directed bench for tff_toggle_bank: main instance (RESET_VAL=A5, 16-bit counter)
// plus a 4-bit-counter instance for saturation and clear.
module tb_tff_toggle_bank;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  int         checks = 0;
  int         failures = 0;

  logic       in_valid, in_ready, res_valid, res_ready, act_clr;
  logic [1:0] in_op;
  logic [7:0] in_data, q, res_mask, res_q;
  logic [15:0] act_cnt;

  logic       s_in_valid, s_in_ready, s_res_valid, s_res_ready, s_act_clr;
  logic [1:0] s_in_op;
  logic [7:0] s_in_data, s_q, s_res_mask, s_res_q;
  logic [3:0] s_act_cnt;

  always #5 clk = ~clk;

  tff_toggle_bank #(.WIDTH(8), .RESET_VAL(8'hA5), .CNT_W(16)) dut (
    .C(clk), .R(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_data(in_data), .Q(q), .res_valid(res_valid), .res_ready(res_ready),
    .res_mask(res_mask), .res_q(res_q), .act_clr(act_clr), .act_cnt(act_cnt)
  );

  tff_toggle_bank #(.WIDTH(8), .RESET_VAL(8'hA5), .CNT_W(4)) dut_s (
    .C(clk), .R(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_op(s_in_op),
    .in_data(s_in_data), .Q(s_q), .res_valid(s_res_valid), .res_ready(s_res_ready),
    .res_mask(s_res_mask), .res_q(s_res_q), .act_clr(s_act_clr), .act_cnt(s_act_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic v, input logic [1:0] op, input logic [7:0] d);
    in_valid = v;
    in_op    = op;
    in_data  = d;
  endtask

  task automatic show(input string step);
    $display("%s: Q=%h res_valid=%b res_mask=%h res_q=%h act_cnt=%0d in_ready=%b",
             step, q, res_valid, res_mask, res_q, act_cnt, in_ready);
  endtask

  initial begin
    cmd(1'b0, 2'b11, 8'h00);
    res_ready = 1'b1;
    act_clr   = 1'b0;
    s_in_valid = 1'b0; s_in_op = 2'b11; s_in_data = 8'h00;
    s_res_ready = 1'b1; s_act_clr = 1'b0;

    // Reset state
    cyc(); cyc();
    show("reset");
    check("rst_q", q, 8'hA5);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_res_mask", res_mask, 8'h00);
    check("rst_res_q", res_q, 8'hA5);
    check("rst_act_cnt", act_cnt, 16'd0);
    check("rst_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;

    // LOAD 0F from A5
    cmd(1'b1, 2'b00, 8'h0F);
    cyc();
    check("load_no_early_result", res_valid, 1'b0);
    cmd(1'b0, 2'b11, 8'h00);
    cyc();
    show("load");
    check("load_res_valid", res_valid, 1'b1);
    check("load_res_mask", res_mask, 8'hAA);
    check("load_res_q", res_q, 8'h0F);
    check("load_q", q, 8'h0F);
    check("load_act_cnt", act_cnt, 16'd4);
    cyc();
    check("load_drained", res_valid, 1'b0);

    // Back-to-back: TOGGLE 01, TOGGLE 01, LOAD FF
    cmd(1'b1, 2'b01, 8'h01);
    cyc();
    cmd(1'b1, 2'b01, 8'h01);
    cyc();
    show("b2b_1");
    check("b2b1_mask", res_mask, 8'h01);
    check("b2b1_q", q, 8'h0E);
    check("b2b1_cnt", act_cnt, 16'd5);
    cmd(1'b1, 2'b00, 8'hFF);
    cyc();
    show("b2b_2");
    check("b2b2_valid", res_valid, 1'b1);
    check("b2b2_mask", res_mask, 8'h01);
    check("b2b2_q", q, 8'h0F);
    check("b2b2_cnt", act_cnt, 16'd6);
    cmd(1'b0, 2'b11, 8'h00);
    cyc();
    show("b2b_3");
    check("b2b3_mask", res_mask, 8'hF0);
    check("b2b3_res_q", res_q, 8'hFF);
    check("b2b3_cnt", act_cnt, 16'd10);
    cyc();
    check("b2b_drained", res_valid, 1'b0);

    // Backpressure: two commands offered while res_ready is low
    res_ready = 1'b0;
    cmd(1'b1, 2'b01, 8'h03);
    cyc();
    cmd(1'b1, 2'b01, 8'h0C);
    cyc();
    show("bp_first");
    check("bp_first_mask", res_mask, 8'h03);
    check("bp_first_q", q, 8'hFC);
    check("bp_cnt", act_cnt, 16'd12);
    check("bp_in_ready_low", in_ready, 1'b0);
    cmd(1'b0, 2'b11, 8'h00);
    for (int i = 0; i < 2; i++) begin
      cyc();
      show("bp_hold");
      check("bp_hold_valid", res_valid, 1'b1);
      check("bp_hold_mask", res_mask, 8'h03);
      check("bp_hold_res_q", res_q, 8'hFC);
      check("bp_hold_q", q, 8'hFC);
      check("bp_hold_cnt", act_cnt, 16'd12);
      check("bp_hold_in_ready", in_ready, 1'b0);
    end
    res_ready = 1'b1;
    cyc();
    show("bp_second");
    check("bp_second_valid", res_valid, 1'b1);
    check("bp_second_mask", res_mask, 8'h0C);
    check("bp_second_q", q, 8'hF0);
    check("bp_second_cnt", act_cnt, 16'd14);
    cyc();
    check("bp_drained", res_valid, 1'b0);

    // LOAD 3C, RESTORE, NOP back-to-back
    cmd(1'b1, 2'b00, 8'h3C);
    cyc();
    cmd(1'b1, 2'b10, 8'h77);
    cyc();
    show("ld3c");
    check("ld3c_mask", res_mask, 8'hCC);
    check("ld3c_q", q, 8'h3C);
    check("ld3c_cnt", act_cnt, 16'd18);
    cmd(1'b1, 2'b11, 8'h5A);
    cyc();
    show("restore");
    check("restore_mask", res_mask, 8'h99);
    check("restore_q", q, 8'hA5);
    check("restore_cnt", act_cnt, 16'd22);
    cmd(1'b0, 2'b11, 8'h00);
    cyc();
    show("nop");
    check("nop_valid", res_valid, 1'b1);
    check("nop_mask", res_mask, 8'h00);
    check("nop_q", q, 8'hA5);
    check("nop_cnt", act_cnt, 16'd22);
    cyc();

    // Reset mid-stream: one result pending in B, one command in A
    res_ready = 1'b0;
    cmd(1'b1, 2'b01, 8'hFF);
    cyc();
    cmd(1'b1, 2'b01, 8'h01);
    cyc();
    check("mid_pending_q", q, 8'h5A);
    cmd(1'b0, 2'b11, 8'h00);
    rst_n = 1'b0;
    #1;
    show("mid_reset");
    check("mid_rst_q", q, 8'hA5);
    check("mid_rst_valid", res_valid, 1'b0);
    check("mid_rst_cnt", act_cnt, 16'd0);
    check("mid_rst_in_ready", in_ready, 1'b1);
    cyc();
    rst_n = 1'b1;
    res_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      check("post_rst_no_result", res_valid, 1'b0);
      check("post_rst_q", q, 8'hA5);
    end

    // Saturation and clear on the 4-bit counter instance
    s_in_valid = 1'b1; s_in_op = 2'b01; s_in_data = 8'hFF;
    cyc();
    cyc();
    check("sat_first", s_act_cnt, 4'd8);
    s_in_valid = 1'b0;
    cyc();
    $display("sat: act_cnt=%0d Q=%h", s_act_cnt, s_q);
    check("sat_max", s_act_cnt, 4'd15);
    s_in_valid = 1'b1; s_in_data = 8'h01;
    cyc();
    s_in_valid = 1'b0;
    cyc();
    check("sat_hold", s_act_cnt, 4'd15);
    check("sat_hold_mask", s_res_mask, 8'h01);
    s_in_valid = 1'b1; s_in_data = 8'h03;
    cyc();
    s_in_valid = 1'b0;
    s_act_clr = 1'b1;
    cyc();
    s_act_clr = 1'b0;
    $display("clr: act_cnt=%0d res_mask=%h", s_act_cnt, s_res_mask);
    check("clr_cnt", s_act_cnt, 4'd0);
    check("clr_mask", s_res_mask, 8'h03);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tff_toggle_bank.md
# tff_toggle_bank

Register bank built only from toggle flip-flops: converts D-style and T-style commands into per-bit toggle masks (T = D ^ Q), applies them, and reports each applied mask plus a saturating toggle-activity count. It is the D-to-T direction of our TFF/DFF cell mapping flow, and it serves as the synthesizable reference model for the DFF+XOR to TFF recognition pass and as an activity-measurement block in test designs.

## Interface
- `WIDTH`, 8: bank width in bits, 1..64.
- `RESET_VAL`, 0: value of `Q` after reset, WIDTH bits.
- `CNT_W`, 16: activity counter width, at least clog2(WIDTH+1).

Ports:
- `C`  in  1: clock, rising edge.
- `R`  in  1: reset, asynchronous, active-low.
- `in_valid`  in  1: command valid.
- `in_ready`  out  1: command accepted when `in_valid && in_ready`.
- `in_op`  in  2: opcode. 00 LOAD (T = data ^ Q); 01 TOGGLE (T = data); 10 RESTORE (T = Q ^ RESET_VAL, data ignored); 11 NOP (T = 0).
- `in_data`  in  WIDTH: command operand.
- `Q`  out  WIDTH: current bank state, registered.
- `res_valid`  out  1: applied-mask result valid.
- `res_ready`  in  1: result consumer ready.
- `res_mask`  out  WIDTH: toggle mask applied by the command.
- `res_q`  out  WIDTH: `Q` after applying `res_mask`.
- `act_clr`  in  1: synchronous clear of `act_cnt`.
- `act_cnt`  out  CNT_W: saturating total of toggled bits.

## Operation
- Stage A is the accept register. A command is captured into `a_op`/`a_data` and `a_valid` is set.
- Stage B is compute-and-apply. In the cycle `a_valid` is set and the stage advances:
  - T is computed from `a_op` and the current `Q`.
  - `Q <= Q ^ T`.
  - `res_mask <= T`, `res_q <= Q ^ T`, `res_valid <= 1`.
  - `act_cnt` is loaded in the same edge with min(act_cnt + popcount(T), 2^CNT_W - 1).
- Stall rule: the stage advances only when `!res_valid || res_ready`.
- `in_ready = !a_valid || advance`, so a single-entry stage A runs at full throughput with no skid.
- Back-to-back commands: stage B always sees `Q` already updated by the previous command. No forwarding path is needed because apply and compute happen in the same stage.
- NOP still produces a result (mask 0) and adds 0 to the counter.
- `act_clr` has priority over accumulation: when it coincides with an applied mask, `act_cnt <= 0` and that mask's popcount is dropped.
- Saturation: once at the maximum, `act_cnt` holds until cleared.
- `Q` changes only on stage-B advance. It never changes while `res_valid && !res_ready`.

## Timing
- On reset (`R` low, asynchronous): `Q=RESET_VAL`, `a_valid=0`, `res_valid=0`, `res_mask=0`, `res_q=RESET_VAL`, `act_cnt=0`.
- `in_ready` is 1 during and after reset, provided `a_valid=0`.
- Latency: command accepted at edge N → `Q`, `res_*` and `act_cnt` updated at edge N+1.
- Throughput: one command per cycle while `res_ready` is held high.
- `res_valid` stays high, with `res_mask`/`res_q` stable, until `res_ready` is sampled high.
- Reset mid-operation: in-flight commands in A and B are discarded and no result is emitted.
- Reset deassertion is synchronized externally, so the first accept may occur on the first edge after `R` rises.

## Structure
- Shared package `tff_pkg`:
  - opcode constants `TFF_OP_LOAD/TOGGLE/RESTORE/NOP`
  - a 2-bit opcode typedef
  - function `tff_mask(op, data, q, rst)` returning T
- Sub-module `tff_popcount`: combinational, WIDTH in, clog2(WIDTH+1) out, shared with the recognition-pass test harness.
- Bank flops are explicit toggle updates (`Q <= Q ^ T`) so that synthesis maps them onto `$_TFF_`-style cells through the recognition pass.

## Test plan
- **Reset:** RESET_VAL=8'hA5, assert R low mid-stream → Q=A5, res_valid=0, act_cnt=0 within the same cycle, no stale result after release.
- **LOAD:** Q=A5, LOAD 8'h0F → res_mask=AA, res_q=0F, Q=0F, act_cnt=+4, all one cycle after accept.
- **Back-to-back:** TOGGLE 01, TOGGLE 01, LOAD FF with res_ready=1 → masks 01, 01, FF^current Q. Three results on consecutive cycles, act_cnt +1,+1,+popcount.
- **Backpressure:** res_ready=0 for 3 cycles with 2 commands offered → first result held stable, in_ready drops after stage A fills, Q unchanged, no command lost when res_ready returns.
- **Saturation and clear:** CNT_W=4, issue TOGGLE FF twice → act_cnt=15 and holds. act_clr together with TOGGLE 03 → act_cnt=0.
- **RESTORE and NOP:** Q=3C, RESTORE with RESET_VAL=A5 → mask 99, Q=A5. NOP → res_mask=0, Q and act_cnt unchanged.
